// File: rtl/cheri_pkg.sv
// cheri_pkg: shared widths and state encodings for the CHERI revocation-map blocks
package cheri_pkg;
  localparam int TSMAP_AW = 16;
  localparam int TSMAP_DW = 32;
  typedef enum logic {SWEEP, RUN} sweep_state_e;
endpackage

// File: rtl/cheri_tsmap_ctrl.sv
// cheri_tsmap_ctrl: arbitrates one SRAM between the revocation read port, the clear sweep and a bus slave
module cheri_tsmap_ctrl
  import cheri_pkg::*;
#(
  parameter int TSMapSize = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tsmap_cs_i,
  input  logic [TSMAP_AW-1:0] tsmap_addr_i,
  output logic [TSMAP_DW-1:0] tsmap_rdata_o,
  input  logic                bus_req_i,
  input  logic                bus_we_i,
  input  logic [TSMAP_AW-1:0] bus_addr_i,
  input  logic [3:0]          bus_be_i,
  input  logic [TSMAP_DW-1:0] bus_wdata_i,
  output logic                bus_gnt_o,
  output logic                bus_rvalid_o,
  output logic [TSMAP_DW-1:0] bus_rdata_o,
  output logic                bus_err_o,
  output logic                mem_cs_o,
  output logic                mem_we_o,
  output logic [TSMAP_AW-1:0] mem_addr_o,
  output logic [3:0]          mem_be_o,
  output logic [TSMAP_DW-1:0] mem_wdata_o,
  input  logic [TSMAP_DW-1:0] mem_rdata_i,
  input  logic                init_req_i,
  output logic                init_busy_o
);
  localparam logic [TSMAP_AW:0] Size = (TSMAP_AW+1)'(TSMapSize);
  sweep_state_e state_q, state_d;
  logic [TSMAP_AW-1:0] cnt_q, cnt_d;
  logic run, last, rev_mem, sweep_wr, bus_mem;
  logic rev_q, rvalid_q, rd_q, err_q;
  assign run      = state_q == RUN;
  assign last     = {1'b0, cnt_q} == Size - 1'b1;
  assign rev_mem  = tsmap_cs_i & run & ~rst_i & ({1'b0, tsmap_addr_i} < Size);
  assign sweep_wr = ~tsmap_cs_i & ~run & ~rst_i;
  assign bus_gnt_o = bus_req_i & ~tsmap_cs_i & run & ~rst_i;
  assign bus_mem  = bus_gnt_o & ({1'b0, bus_addr_i} < Size);
  // grant excludes tsmap_cs_i and sweep only runs outside RUN, so these sources never overlap
  assign mem_cs_o    = rev_mem | sweep_wr | bus_mem;
  assign mem_we_o    = sweep_wr | (bus_mem & bus_we_i);
  assign mem_addr_o  = rev_mem ? tsmap_addr_i : sweep_wr ? cnt_q : bus_mem ? bus_addr_i : '0;
  assign mem_be_o    = sweep_wr ? 4'hF : bus_mem ? bus_be_i : 4'h0;
  assign mem_wdata_o = bus_mem ? bus_wdata_i : '0;
  assign init_busy_o = ~run;
  always_comb begin
    cnt_d   = sweep_wr ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    state_d = (run & init_req_i) ? SWEEP : (sweep_wr & last) ? RUN : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SWEEP;
      cnt_q    <= '0;
      rev_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rev_q    <= rev_mem;
      rvalid_q <= bus_gnt_o;
      rd_q     <= bus_mem & ~bus_we_i;
      err_q    <= bus_gnt_o & ~bus_mem;
    end
  end
  // the map reads as cleared for the whole sweep, whatever the SRAM still holds
  assign tsmap_rdata_o = (rev_q & run & ~rst_i) ? mem_rdata_i : '0;
  assign bus_rvalid_o  = rvalid_q & ~rst_i;
  assign bus_rdata_o   = (rvalid_q & rd_q & ~rst_i) ? mem_rdata_i : '0;
  assign bus_err_o     = rvalid_q & err_q & ~rst_i;
endmodule

// File: tb/tb_cheri_tsmap_ctrl.sv
// tb_cheri_tsmap_ctrl: scoreboard bench with an SRAM model, TSMapSize=8
module tb_cheri_tsmap_ctrl;
  localparam int N = 8;
  logic clk = 0, rst_i = 1;
  logic tsmap_cs_i = 0;
  logic [15:0] tsmap_addr_i = 0;
  logic [31:0] tsmap_rdata_o;
  logic bus_req_i = 0, bus_we_i = 0;
  logic [15:0] bus_addr_i = 0;
  logic [3:0] bus_be_i = 0;
  logic [31:0] bus_wdata_i = 0;
  logic bus_gnt_o, bus_rvalid_o, bus_err_o;
  logic [31:0] bus_rdata_o;
  logic mem_cs_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 0;
  logic init_req_i = 0, init_busy_o;

  always #5 clk = ~clk;

  cheri_tsmap_ctrl #(.TSMapSize(N)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tsmap_cs_i(tsmap_cs_i), .tsmap_addr_i(tsmap_addr_i), .tsmap_rdata_o(tsmap_rdata_o),
    .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i), .bus_be_i(bus_be_i),
    .bus_wdata_i(bus_wdata_i), .bus_gnt_o(bus_gnt_o), .bus_rvalid_o(bus_rvalid_o),
    .bus_rdata_o(bus_rdata_o), .bus_err_o(bus_err_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .init_req_i(init_req_i), .init_busy_o(init_busy_o)
  );

  logic [31:0] mem [N];
  initial for (int i = 0; i < N; i++) mem[i] = 32'hFFFF_FFFF;
  always @(posedge clk) begin
    if (mem_cs_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[2:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o[2:0]];
      end
    end
  end

  typedef struct packed {logic we; logic [15:0] addr; logic [3:0] be; logic [31:0] wdata;} mem_t;
  typedef struct packed {logic [31:0] due; logic err; logic [31:0] rdata;} bus_t;
  mem_t mem_q[$];
  bus_t bus_q[$];
  logic [31:0] rev_q[$];
  int checks = 0, failures = 0;
  logic [31:0] cyc = 0;
  logic cs_prev = 0;
  mem_t mexp;
  bus_t bexp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_cs_o) begin
      if (mem_q.size() == 0) chk("mem_unexpected", {mem_we_o, mem_addr_o}, 64'h0);
      else begin
        mexp = mem_q.pop_front();
        chk("mem_access", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, mexp);
      end
    end else chk("mem_idle", {mem_addr_o, mem_be_o, mem_wdata_o}, 64'h0);
    if (bus_rvalid_o) begin
      if (bus_q.size() == 0) chk("rvalid_unexpected", bus_rvalid_o, 0);
      else begin
        bexp = bus_q.pop_front();
        chk("rvalid_cycle", cyc, bexp.due);
        chk("bus_resp", {bus_err_o, bus_rdata_o}, {bexp.err, bexp.rdata});
      end
    end else begin
      chk("bus_idle", {bus_err_o, bus_rdata_o}, 64'h0);
      if (bus_q.size() != 0 && bus_q[0].due <= cyc) begin
        chk("rvalid_missing", 0, 1);
        void'(bus_q.pop_front());
      end
    end
    if (cs_prev) begin
      if (rev_q.size() == 0) chk("rev_unexpected", 1, 0);
      else chk("rev_rdata", tsmap_rdata_o, rev_q.pop_front());
    end
    cs_prev = tsmap_cs_i;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int words);
    for (int i = 0; i < words; i++) mem_q.push_back({1'b1, 16'(i), 4'hF, 32'h0});
  endtask

  task automatic bus_xfer(input logic we, input logic [15:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic in_rng, input logic [31:0] rdata);
    int n = 0;
    bus_t e;
    if (in_rng) mem_q.push_back({we, addr, be, wdata});
    bus_req_i = 1; bus_we_i = we; bus_addr_i = addr; bus_be_i = be; bus_wdata_i = wdata;
    do begin @(negedge clk); n++; end while (!bus_gnt_o && n < 20);
    chk("bus_grant", bus_gnt_o, 1);
    e.due = cyc + 1; e.err = !in_rng; e.rdata = rdata;
    bus_q.push_back(e);
    tick();
    bus_req_i = 0; bus_we_i = 0; bus_addr_i = 0; bus_be_i = 0; bus_wdata_i = 0;
  endtask

  task automatic sweep_len(input string name, input int exp);
    int n = 0;
    while (init_busy_o && n < 50) begin tick(); n++; end
    chk(name, n, exp);
  endtask

  initial begin
    int n;
    bus_t e;
    // reset with a request pending: nothing may be granted or accessed
    bus_req_i = 1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_outputs", {bus_gnt_o, bus_rvalid_o, bus_err_o, bus_rdata_o, mem_cs_o}, 64'h0);
    chk("rst_trdata", tsmap_rdata_o, 0);
    chk("rst_busy", init_busy_o, 1);
    tick();
    rst_i = 0; bus_req_i = 0;
    push_sweep(N);
    sweep_len("sweep_after_reset", N);
    // byte write then read back
    bus_xfer(1, 16'd3, 4'h1, 32'hA5, 1, 32'h0);
    bus_xfer(0, 16'd3, 4'hF, 32'h0, 1, 32'h0000_00A5);
    // write immediately followed by revocation read of the same word
    bus_xfer(1, 16'd5, 4'hF, 32'h1234_5678, 1, 32'h0);
    tsmap_cs_i = 1; tsmap_addr_i = 5;
    rev_q.push_back(32'h1234_5678);
    mem_q.push_back({1'b0, 16'd5, 4'h0, 32'h0});
    tick();
    // revocation read collides with a bus request
    tsmap_addr_i = 3;
    rev_q.push_back(32'h0000_00A5);
    mem_q.push_back({1'b0, 16'd3, 4'h0, 32'h0});
    mem_q.push_back({1'b0, 16'd3, 4'hF, 32'h0});
    bus_req_i = 1; bus_we_i = 0; bus_addr_i = 3; bus_be_i = 4'hF;
    @(negedge clk);
    chk("gnt_blocked", bus_gnt_o, 0);
    tick();
    tsmap_cs_i = 0;
    @(negedge clk);
    chk("gnt_after_rev", bus_gnt_o, 1);
    e.due = cyc + 1; e.err = 0; e.rdata = 32'h0000_00A5;
    bus_q.push_back(e);
    tick();
    bus_req_i = 0; bus_addr_i = 0; bus_be_i = 0;
    // out-of-range bus and revocation accesses
    bus_xfer(0, 16'd8, 4'hF, 32'h0, 0, 32'h0);
    bus_xfer(1, 16'hFFFF, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
    tsmap_cs_i = 1; tsmap_addr_i = 8;
    rev_q.push_back(32'h0);
    tick();
    tsmap_cs_i = 0;
    // init request, revocation reads pause the sweep two cycles, second request ignored
    init_req_i = 1;
    push_sweep(N);
    tick();
    init_req_i = 0;
    tsmap_cs_i = 1; tsmap_addr_i = 5;
    rev_q.push_back(32'h0);
    rev_q.push_back(32'h0);
    n = 0;
    while (init_busy_o && n < 50) begin
      if (n == 2) tsmap_cs_i = 0;
      init_req_i = (n == 4);
      tick();
      n++;
    end
    init_req_i = 0; tsmap_cs_i = 0;
    chk("sweep_paused_len", n, N + 2);
    tsmap_cs_i = 1; tsmap_addr_i = 5;
    rev_q.push_back(32'h0);
    mem_q.push_back({1'b0, 16'd5, 4'h0, 32'h0});
    tick();
    tsmap_cs_i = 0;
    // reset right after a grant drops the response
    mem_q.push_back({1'b0, 16'd3, 4'hF, 32'h0});
    bus_req_i = 1; bus_addr_i = 3; bus_be_i = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_gnt_o && n < 20);
    chk("gnt_before_rst", bus_gnt_o, 1);
    tick();
    bus_req_i = 0; bus_addr_i = 0; bus_be_i = 0;
    rst_i = 1;
    @(negedge clk);
    chk("rvalid_in_rst", bus_rvalid_o, 0);
    tick();
    rst_i = 0;
    // reset at sweep word 5 restarts from word 0
    push_sweep(5);
    repeat (5) tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    push_sweep(N);
    sweep_len("sweep_restart", N);
    repeat (3) tick();
    chk("mem_q_empty", mem_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("rev_q_empty", rev_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
